// File: rtl/regfile_port_arbiter.sv
// Round-robin arbiter sharing one single-port register file between
// requesters A and B, with a req/done handshake per access.
module regfile_port_arbiter #(
  parameter int ADDR_W   = 5,
  parameter int DATA_W   = 32,
  parameter int READ_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a_req,
  input  logic              a_wr,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_done,
  input  logic              b_req,
  input  logic              b_wr,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_done,
  output logic [DATA_W-1:0] rdata,
  output logic              busy,
  output logic              rf_we,
  output logic              rf_re,
  output logic [ADDR_W-1:0] rf_addr,
  output logic [DATA_W-1:0] rf_wdata,
  input  logic [DATA_W-1:0] rf_rdata
);

  localparam int CNT_W = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    READ,
    DONE
  } state_t;

  state_t state;

  logic             ptr;
  logic             win;
  logic [CNT_W-1:0] lat_cnt;

  logic              any_req;
  logic              pick_b;
  logic              g_wr;
  logic [ADDR_W-1:0] g_addr;
  logic [DATA_W-1:0] g_wdata;

  // ptr names the requester that wins a tie
  assign any_req = a_req | b_req;
  assign pick_b  = b_req & (~a_req | ptr);
  assign g_wr    = pick_b ? b_wr    : a_wr;
  assign g_addr  = pick_b ? b_addr  : a_addr;
  assign g_wdata = pick_b ? b_wdata : a_wdata;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      ptr      <= 1'b0;
      win      <= 1'b0;
      lat_cnt  <= '0;
      rf_we    <= 1'b0;
      rf_re    <= 1'b0;
      rf_addr  <= '0;
      rf_wdata <= '0;
      rdata    <= '0;
      a_done   <= 1'b0;
      b_done   <= 1'b0;
      busy     <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (any_req) begin
            win     <= pick_b;
            rf_addr <= g_addr;
            busy    <= 1'b1;
            if (g_wr) begin
              rf_wdata <= g_wdata;
              rf_we    <= 1'b1;
              state    <= WRITE;
            end else begin
              rf_re   <= 1'b1;
              lat_cnt <= CNT_W'(READ_LAT - 1);
              state   <= READ;
            end
          end
        end
        WRITE: begin
          rf_we  <= 1'b0;
          a_done <= ~win;
          b_done <= win;
          ptr    <= ~win;
          state  <= DONE;
        end
        READ: begin
          if (lat_cnt != '0) begin
            lat_cnt <= lat_cnt - 1'b1;
          end else begin
            rf_re  <= 1'b0;
            rdata  <= rf_rdata;
            a_done <= ~win;
            b_done <= win;
            ptr    <= ~win;
            state  <= DONE;
          end
        end
        DONE: begin
          a_done <= 1'b0;
          b_done <= 1'b0;
          busy   <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
